hazard_ctrl_sb: RTL and testbench

Parametrised pipeline hazard and flush controller for the 5-stage MIPS core, sitting beside the ID stage and driving the PC, IF/ID, ID/EX and downstream pipeline-register control lines. It adds a per-register load scoreboard for memories with LOAD_LAT > 1. It also adds latched, maskable multi-line interrupts with a registered cause and a saturating stall-cycle counter. Flush and stall priority is: external pause > load-use > SYSCALL/ERET > interrupt > branch mispredict.

---
 rtl/hazard_ctrl_sb_if.sv | 53 +++++
 rtl/hazard_ctrl_sb.sv | 108 ++++++++++
 tb/tb_hazard_ctrl_sb.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_sb_if.sv
`default_nettype none
// ============================================================================
// hazard_ctrl_sb_if : ID/EX/CP0 control bundle for the hazard controller | rev 1.0
// ============================================================================
interface hazard_ctrl_sb_if #(
  parameter int REG_AW     = 5,
  parameter int INTR_LINES = 6,
  parameter int STALL_CW   = 16
);
  logic                  pause;
  logic                  id_valid;
  logic [REG_AW-1:0]     id_rs_addr;
  logic [REG_AW-1:0]     id_rt_addr;
  logic                  id_rs_en;
  logic                  id_rt_en;
  logic                  id_is_syscall;
  logic                  id_is_eret;
  logic                  id_is_branch;
  logic                  id_bpu_mispredict;
  logic                  ex_load;
  logic [REG_AW-1:0]     ex_regdst_addr;
  logic [INTR_LINES-1:0] intr;
  logic                  status_ie;
  logic                  status_exl;
  logic                  status_sys_en;
  logic [INTR_LINES-1:0] status_im;
  logic                  pa_pc_ifid;
  logic                  wash_ifid;
  logic                  pa_idexmemwr;
  logic                  wash_idex;
  logic                  cu_intr;
  logic [INTR_LINES-1:0] intr_cause;
  logic [STALL_CW-1:0]   stall_cycles;

  modport master (
    output pause, id_valid, id_rs_addr, id_rt_addr, id_rs_en, id_rt_en,
           id_is_syscall, id_is_eret, id_is_branch, id_bpu_mispredict,
           ex_load, ex_regdst_addr, intr, status_ie, status_exl,
           status_sys_en, status_im,
    input  pa_pc_ifid, wash_ifid, pa_idexmemwr, wash_idex, cu_intr,
           intr_cause, stall_cycles
  );

  modport slave (
    input  pause, id_valid, id_rs_addr, id_rt_addr, id_rs_en, id_rt_en,
           id_is_syscall, id_is_eret, id_is_branch, id_bpu_mispredict,
           ex_load, ex_regdst_addr, intr, status_ie, status_exl,
           status_sys_en, status_im,
    output pa_pc_ifid, wash_ifid, pa_idexmemwr, wash_idex, cu_intr,
           intr_cause, stall_cycles
  );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl_sb.sv
`default_nettype none
// ============================================================================
// hazard_ctrl_sb : load scoreboard, interrupt latch and flush/stall priority | rev 1.0
// ============================================================================
module hazard_ctrl_sb #(
  parameter int REG_AW     = 5,
  parameter int LOAD_LAT   = 1,
  parameter int INTR_LINES = 6,
  parameter int STALL_CW   = 16
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  hazard_ctrl_sb_if.slave   bus
);
  localparam int c_NREG = 1 << REG_AW;
  localparam int c_SBW  = $clog2(LOAD_LAT + 1);
  localparam logic [c_SBW-1:0] c_SB_INIT = c_SBW'(LOAD_LAT - 1);

  logic [c_SBW-1:0]      r_sb [c_NREG];
  logic [INTR_LINES-1:0] r_pend;
  logic [INTR_LINES-1:0] r_cause;
  logic [STALL_CW-1:0]   r_stall;

  logic                  w_rs_busy;
  logic                  w_rt_busy;
  logic                  w_load_use;
  logic                  w_trap;
  logic                  w_irq;
  logic [INTR_LINES-1:0] w_taken;
  logic                  w_pa_pc;
  logic                  w_wash_if;
  logic                  w_pa_idex;
  logic                  w_wash_idex;
  logic                  w_cu_intr;

  // The EX-stage load itself counts as busy, so LOAD_LAT=1 needs no counter state.
  assign w_rs_busy = (bus.ex_load && bus.ex_regdst_addr == bus.id_rs_addr &&
                      bus.id_rs_addr != '0) || (r_sb[bus.id_rs_addr] != '0);
  assign w_rt_busy = (bus.ex_load && bus.ex_regdst_addr == bus.id_rt_addr &&
                      bus.id_rt_addr != '0) || (r_sb[bus.id_rt_addr] != '0);
  assign w_load_use = bus.id_valid && ((bus.id_rs_en && w_rs_busy) ||
                                       (bus.id_rt_en && w_rt_busy));
  assign w_trap  = (bus.status_sys_en && bus.id_is_syscall) || bus.id_is_eret;
  assign w_irq   = (|(r_pend & bus.status_im)) && bus.status_ie && !bus.status_exl;
  assign w_taken = r_pend & bus.status_im;

  always_comb begin
    w_pa_pc     = 1'b0;
    w_wash_if   = 1'b0;
    w_pa_idex   = 1'b0;
    w_wash_idex = 1'b0;
    w_cu_intr   = 1'b0;
    if (bus.pause) begin
      w_pa_pc   = 1'b1;
      w_pa_idex = 1'b1;
    end else if (w_load_use) begin
      w_pa_pc     = 1'b1;
      w_wash_idex = 1'b1;
    end else if (w_trap) begin
      w_wash_if = 1'b1;
    end else if (w_irq && bus.id_valid) begin
      w_wash_if = 1'b1;
      w_cu_intr = 1'b1;
    end else if (bus.id_is_branch && bus.id_bpu_mispredict) begin
      w_wash_if = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < c_NREG; i++) r_sb[i] <= '0;
    end else if (!bus.pause) begin
      for (int i = 1; i < c_NREG; i++) begin
        if (bus.ex_load && bus.ex_regdst_addr == REG_AW'(i))
          r_sb[i] <= c_SB_INIT;
        else if (r_sb[i] != '0)
          r_sb[i] <= r_sb[i] - c_SBW'(1);
      end
    end
  end

  // Pending bits keep latching while paused so a one-cycle pulse is never dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend  <= '0;
      r_cause <= '0;
    end else begin
      r_pend <= (r_pend | bus.intr) & ~(w_cu_intr ? w_taken : '0);
      if (w_cu_intr) r_cause <= w_taken;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_stall <= '0;
    else if (!bus.pause && w_load_use && r_stall != '1)
      r_stall <= r_stall + STALL_CW'(1);
  end

  assign bus.pa_pc_ifid   = w_pa_pc;
  assign bus.wash_ifid    = w_wash_if;
  assign bus.pa_idexmemwr = w_pa_idex;
  assign bus.wash_idex    = w_wash_idex;
  assign bus.cu_intr      = w_cu_intr;
  assign bus.intr_cause   = r_cause;
  assign bus.stall_cycles = r_stall;
endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl_sb.sv
`default_nettype none
// ============================================================================
// tb_hazard_ctrl_sb : directed vectors with queued expectations, LOAD_LAT 3 and 1 | rev 1.0
// ============================================================================
module tb_hazard_ctrl_sb;
  localparam logic [4:0] NONE  = 5'b00000;
  localparam logic [4:0] STALL = 5'b10010;
  localparam logic [4:0] PAUSE = 5'b10100;
  localparam logic [4:0] WASH  = 5'b01000;
  localparam logic [4:0] INTR  = 5'b01001;

  typedef struct {
    logic [4:0]  ctl;
    logic [5:0]  cause;
    logic [15:0] stall;
  } exp_t;

  logic clk = 1'b1;
  logic rst_n = 1'b0;
  logic pause = 0, id_valid = 0, rs_en = 0, rt_en = 0, syscall = 0, eret = 0;
  logic branch = 0, mispredict = 0, ex_load = 0, ie = 0, exl = 0, sys_en = 0;
  logic [4:0] rs = 0, rt = 0, ex_dst = 0;
  logic [5:0] intr = 0, im = 0;

  exp_t q3[$];
  exp_t q1[$];
  exp_t e3, e1;
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_ctrl_sb_if #(.REG_AW(5), .INTR_LINES(6), .STALL_CW(4))  if3();
  hazard_ctrl_sb_if #(.REG_AW(5), .INTR_LINES(6), .STALL_CW(16)) if1();

  hazard_ctrl_sb #(.REG_AW(5), .LOAD_LAT(3), .INTR_LINES(6), .STALL_CW(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(if3));
  hazard_ctrl_sb #(.REG_AW(5), .LOAD_LAT(1), .INTR_LINES(6), .STALL_CW(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1));

  always_comb begin
    if3.pause = pause;            if1.pause = pause;
    if3.id_valid = id_valid;      if1.id_valid = id_valid;
    if3.id_rs_addr = rs;          if1.id_rs_addr = rs;
    if3.id_rt_addr = rt;          if1.id_rt_addr = rt;
    if3.id_rs_en = rs_en;         if1.id_rs_en = rs_en;
    if3.id_rt_en = rt_en;         if1.id_rt_en = rt_en;
    if3.id_is_syscall = syscall;  if1.id_is_syscall = syscall;
    if3.id_is_eret = eret;        if1.id_is_eret = eret;
    if3.id_is_branch = branch;    if1.id_is_branch = branch;
    if3.id_bpu_mispredict = mispredict; if1.id_bpu_mispredict = mispredict;
    if3.ex_load = ex_load;        if1.ex_load = ex_load;
    if3.ex_regdst_addr = ex_dst;  if1.ex_regdst_addr = ex_dst;
    if3.intr = intr;              if1.intr = intr;
    if3.status_ie = ie;           if1.status_ie = ie;
    if3.status_exl = exl;         if1.status_exl = exl;
    if3.status_sys_en = sys_en;   if1.status_sys_en = sys_en;
    if3.status_im = im;           if1.status_im = im;
  end

  task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic exp3(input logic [4:0] c, input logic [5:0] ca, input int s);
    q3.push_back('{ctl: c, cause: ca, stall: 16'(s)});
  endtask

  task automatic exp1(input logic [4:0] c, input int s);
    q1.push_back('{ctl: c, cause: 6'd0, stall: 16'(s)});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: consumes one expectation per DUT each cycle, away from the active edge.
  always @(negedge clk) begin
    if (q3.size() > 0) begin
      e3 = q3.pop_front();
      cmp("ll3_ctl", {11'd0, if3.pa_pc_ifid, if3.wash_ifid, if3.pa_idexmemwr,
                      if3.wash_idex, if3.cu_intr}, {11'd0, e3.ctl});
      cmp("ll3_cause", {10'd0, if3.intr_cause}, {10'd0, e3.cause});
      cmp("ll3_stall", {12'd0, if3.stall_cycles}, e3.stall);
    end
    if (q1.size() > 0) begin
      e1 = q1.pop_front();
      cmp("ll1_ctl", {11'd0, if1.pa_pc_ifid, if1.wash_ifid, if1.pa_idexmemwr,
                      if1.wash_idex, if1.cu_intr}, {11'd0, e1.ctl});
      cmp("ll1_stall", if1.stall_cycles, e1.stall);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // reset state
    exp3(NONE, 0, 0); exp1(NONE, 0); tick();
    rst_n = 1'b1;
    exp3(NONE, 0, 0); exp1(NONE, 0); tick();

    // immediate dependent on a load: 1 stall at LOAD_LAT=1, 3 stalls at LOAD_LAT=3
    ex_load = 1; ex_dst = 5; id_valid = 1; rs_en = 1; rs = 5;
    exp3(STALL, 0, 0); exp1(STALL, 0); tick();
    ex_load = 0;
    exp3(STALL, 0, 1); exp1(NONE, 1); tick();
    exp3(STALL, 0, 2); tick();
    exp3(NONE, 0, 3); tick();

    // one independent instruction between load and use: 2 stalls
    rs_en = 0; rs = 0; rt_en = 1; rt = 3; ex_load = 1; ex_dst = 7;
    exp3(NONE, 0, 3); tick();
    ex_load = 0; rt = 7;
    exp3(STALL, 0, 3); tick();
    exp3(STALL, 0, 4); tick();
    exp3(NONE, 0, 5); tick();

    // load to $0 is never tracked
    ex_load = 1; ex_dst = 0; rt = 0;
    exp3(NONE, 0, 5); tick();
    ex_load = 0;
    exp3(NONE, 0, 5); tick();

    // pause mid-stall freezes counters; 2 stalls remain afterwards
    ex_load = 1; ex_dst = 7; rt = 7;
    exp3(STALL, 0, 5); tick();
    ex_load = 0; pause = 1;
    repeat (4) begin exp3(PAUSE, 0, 6); tick(); end
    pause = 0;
    exp3(STALL, 0, 6); tick();
    exp3(STALL, 0, 7); tick();
    exp3(NONE, 0, 8); tick();

    // one-cycle intr pulse during a stall is taken on the first clean cycle
    ie = 1; im = 6'b000100; rt_en = 0; rs_en = 1; rs = 9;
    ex_load = 1; ex_dst = 9; intr = 6'b000100;
    exp3(STALL, 0, 8); tick();
    ex_load = 0; intr = 0;
    exp3(STALL, 0, 9); tick();
    exp3(STALL, 0, 10); tick();
    exp3(INTR, 0, 11); tick();
    exp3(NONE, 6'b000100, 11); tick();

    // syscall beats pending interrupt and mispredict; masked bit stays pending
    im = 6'b100100; id_valid = 0; rs_en = 0; intr = 6'b100001;
    exp3(NONE, 6'b000100, 11); tick();
    intr = 0; id_valid = 1; sys_en = 1; syscall = 1; branch = 1; mispredict = 1;
    exp3(WASH, 6'b000100, 11); tick();
    syscall = 0; branch = 0; mispredict = 0;
    exp3(INTR, 6'b000100, 11); tick();
    id_valid = 0;
    exp3(NONE, 6'b100000, 11); tick();

    // mispredict alone, syscall without enable, eret
    id_valid = 1; branch = 1; mispredict = 1;
    exp3(WASH, 6'b100000, 11); tick();
    branch = 0; mispredict = 0; sys_en = 0; syscall = 1;
    exp3(NONE, 6'b100000, 11); tick();
    syscall = 0; eret = 1;
    exp3(WASH, 6'b100000, 11); tick();
    eret = 0;

    // EXL blocks the interrupt; the retained bit 0 is taken once EXL drops
    im = 6'b000001; exl = 1;
    exp3(NONE, 6'b100000, 11); tick();
    exl = 0;
    exp3(INTR, 6'b100000, 11); tick();
    id_valid = 0;
    exp3(NONE, 6'b000001, 11); tick();

    // 20 stall cycles saturate the 4-bit counter at 15
    im = 0; ie = 0; id_valid = 1; rs_en = 1; rs = 10; ex_load = 1; ex_dst = 10;
    for (int k = 0; k < 20; k++) begin
      exp3(STALL, 6'b000001, (11 + k > 15) ? 15 : 11 + k);
      tick();
    end

    // asynchronous reset mid-stall clears everything within the cycle
    ex_load = 0; rst_n = 0;
    exp3(NONE, 0, 0); tick();
    rst_n = 1;
    exp3(NONE, 0, 0); tick();
    exp3(NONE, 0, 0); tick();

    cmp("drain", 16'(q3.size() + q1.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
